neighbor_loss_handler: RTL
==========================

Name: neighbor_loss_handler

Overview:
- Sits directly downstream of the neighbour table in the router.
- Consumes its expiry outputs (invalid id, valid, parent-invalid flag) and buffers lost ids in a small FIFO, then drains them to the routing table as purge requests.
- When the lost neighbour is the current parent, runs a re-join FSM: broadcast join request, wait for ack, retry, give up.
- Owns the parent id and feeds it back to the neighbour table's parent inputs.

Parameters:
- FIFO_DEPTH, 4, lost-id FIFO entries (power of two, >=2).
- ACK_TIMEOUT, 200, nocclk cycles to wait for a join ack per attempt.
- MAX_RETRY, 3, join attempts before declaring orphan.

Ports:
- nocclk  in  1  clock.
- rst  in  1  reset.
- in_invalid_id  in  types::node_id_t  expired neighbour id.
- in_invalid_id_valid  in  1  single-cycle expiry pulse.
- in_is_parent_id_invalid  in  1  expired id is current parent (qualified by valid).
- out_purge_id  out  types::node_id_t  id to purge from routing table.
- out_purge_valid  out  1  purge request valid.
- in_purge_ready  in  1  routing table accepts purge.
- in_join_start  in  1  pulse: begin join (boot / manual rejoin).
- out_join_req_valid  out  1  request tx to broadcast a join packet.
- in_join_req_ready  in  1  tx accepted join request.
- in_join_ack_valid  in  1  join ack received.
- in_join_ack_id  in  types::node_id_t  sender of ack (new parent).
- out_parent_id  out  types::node_id_t  current parent.
- out_parent_valid  out  1  parent id valid.
- out_orphan  out  1  retries exhausted.
- out_fifo_overflow  out  1  sticky: an expiry was dropped.

Behaviour:
- One clock, nocclk; rst is asynchronous, active-high.
- Reset values: all outputs 0, FIFO empty, FSM IDLE, retry count 0, timer 0.
- FIFO push: on in_invalid_id_valid.
  - Push when full and no pop this cycle: id dropped, out_fifo_overflow set. The flag clears only on rst.
  - Push and pop in the same cycle is allowed when full.
- FIFO pop: out_purge_valid = !empty; out_purge_id = head (registered storage, no bypass). Push-to-valid latency is 1 cycle.
  - Pop when out_purge_valid && in_purge_ready.
  - Head stays stable while valid && !ready.
- Pointers are $clog2(FIFO_DEPTH)+1 bits with wrap bit; full/empty derived from pointer compare.
- Parent loss (in_invalid_id_valid && in_is_parent_id_invalid && out_parent_valid):
  - Next cycle: out_parent_valid=0, retry count=0, FSM -> JOIN_REQ.
  - The id is also pushed to the FIFO.
- FSM states:
  - IDLE: in_join_start -> JOIN_REQ, retry=0.
  - JOIN_REQ: out_join_req_valid=1, held until in_join_req_ready. On handshake -> WAIT_ACK, timer=0.
  - WAIT_ACK:
    - in_join_ack_valid -> IDLE; out_parent_id<=in_join_ack_id, out_parent_valid<=1.
    - Else timer increments. At timer==ACK_TIMEOUT-1, retry increments: if retry+1 < MAX_RETRY -> JOIN_REQ, else -> ORPHAN.
    - Ack in the timeout cycle wins over timeout.
  - ORPHAN: out_orphan=1.
    - in_join_start -> JOIN_REQ, retry=0, out_orphan=0.
    - Late ack accepted -> IDLE with parent set, out_orphan=0.
- Acks in IDLE or JOIN_REQ are ignored.
- in_join_start is ignored in JOIN_REQ/WAIT_ACK.
- Timer width is $clog2(ACK_TIMEOUT+1). Retry width is $clog2(MAX_RETRY+1).
- rst mid-operation: FSM, FIFO, parent, flags return to reset values on the same edge. No pending request survives.

Decomposition:
- Shared package gets a new typedef, neighbor_loss_state_t (IDLE, JOIN_REQ, WAIT_ACK, ORPHAN).
- types::node_id_t is reused.
- One sub-module: id_fifo, a generic node_id_t sync FIFO with valid/ready and overflow pulse, reusable by other router stages.

Test Plan:
1. Three expiry pulses ids 0x11, 0x22, 0x33 with in_purge_ready=0, then ready=1 -> purge ids emitted 0x11, 0x22, 0x33 in order, one per cycle; out_purge_valid low after.
2. Five expiry pulses (FIFO_DEPTH=4), ready=0 -> out_fifo_overflow=1; drain yields only the first four ids.
3. in_join_start, join ready after 2 cycles, ack id 0x05 after 10 cycles -> out_parent_id=0x05, out_parent_valid=1, FSM IDLE.
4. Parent 0x05 set, expiry pulse 0x05 with in_is_parent_id_invalid=1 -> out_parent_valid=0 next cycle, out_join_req_valid=1, 0x05 queued for purge.
5. Join accepted, no ack (ACK_TIMEOUT=200, MAX_RETRY=3) -> three join requests spaced 200 cycles after each accept; out_orphan=1 after the third timeout. A late ack 0x07 then clears orphan and sets the parent.
6. rst asserted during WAIT_ACK with FIFO holding two ids -> all outputs 0 asynchronously; no purge or join request after release.

Source files
------------

// File: rtl/neighbor_loss_handler_pkg.sv
// rtl/neighbor_loss_handler_pkg.sv - shared router types: node id and neighbour-loss FSM states
package types;

   typedef logic [7:0] node_id_t;

   typedef enum logic [1:0] {
      IDLE,
      JOIN_REQ,
      WAIT_ACK,
      ORPHAN
   } neighbor_loss_state_t;

endpackage

// File: rtl/neighbor_loss_handler_id_fifo.sv
// rtl/neighbor_loss_handler_id_fifo.sv - generic node id sync FIFO with valid/ready pop and overflow pulse
module id_fifo
   import types::*;
#(
   parameter int DEPTH = 4
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     push_valid,
   input  node_id_t push_id,
   output logic     pop_valid,
   output node_id_t pop_id,
   input  logic     pop_ready,
   output logic     overflow
);

   localparam int AW = $clog2(DEPTH);

   node_id_t    mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        empty;
   logic        full;
   logic        pop;
   logic        push_ok;

   // Extra wrap bit distinguishes full from empty when the index bits match.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop     = !empty && pop_ready;
   assign push_ok = push_valid && (!full || pop);

   assign pop_valid = !empty;
   assign pop_id    = mem[rd_ptr[AW-1:0]];
   assign overflow  = push_valid && full && !pop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= push_id;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/neighbor_loss_handler.sv
// rtl/neighbor_loss_handler.sv - buffers expired neighbour ids for purge and re-joins when the parent is lost
module neighbor_loss_handler
   import types::*;
#(
   parameter int FIFO_DEPTH  = 4,
   parameter int ACK_TIMEOUT = 200,
   parameter int MAX_RETRY   = 3
) (
   input  logic     nocclk,
   input  logic     rst,
   input  node_id_t in_invalid_id,
   input  logic     in_invalid_id_valid,
   input  logic     in_is_parent_id_invalid,
   output node_id_t out_purge_id,
   output logic     out_purge_valid,
   input  logic     in_purge_ready,
   input  logic     in_join_start,
   output logic     out_join_req_valid,
   input  logic     in_join_req_ready,
   input  logic     in_join_ack_valid,
   input  node_id_t in_join_ack_id,
   output node_id_t out_parent_id,
   output logic     out_parent_valid,
   output logic     out_orphan,
   output logic     out_fifo_overflow
);

   localparam int TW = $clog2(ACK_TIMEOUT + 1);
   localparam int RW = $clog2(MAX_RETRY + 1);

   neighbor_loss_state_t state, state_nxt;
   logic [TW-1:0]        timer, timer_nxt;
   logic [RW-1:0]        retry, retry_nxt;
   node_id_t             parent_id_nxt;
   logic                 parent_valid_nxt;
   logic                 overflow_pulse;
   logic                 parent_lost;

   id_fifo #(.DEPTH(FIFO_DEPTH)) u_id_fifo (
      .clk        (nocclk),
      .rst        (rst),
      .push_valid (in_invalid_id_valid),
      .push_id    (in_invalid_id),
      .pop_valid  (out_purge_valid),
      .pop_id     (out_purge_id),
      .pop_ready  (in_purge_ready),
      .overflow   (overflow_pulse)
   );

   assign parent_lost        = in_invalid_id_valid && in_is_parent_id_invalid && out_parent_valid;
   assign out_join_req_valid = (state == JOIN_REQ);
   assign out_orphan         = (state == ORPHAN);

   always_ff @(posedge nocclk or posedge rst) begin
      if (rst) begin
         state             <= IDLE;
         timer             <= '0;
         retry             <= '0;
         out_parent_id     <= '0;
         out_parent_valid  <= 1'b0;
         out_fifo_overflow <= 1'b0;
      end else begin
         state             <= state_nxt;
         timer             <= timer_nxt;
         retry             <= retry_nxt;
         out_parent_id     <= parent_id_nxt;
         out_parent_valid  <= parent_valid_nxt;
         out_fifo_overflow <= out_fifo_overflow | overflow_pulse;
      end
   end

   // Losing the parent restarts the join sequence from any state.
   always_comb begin
      state_nxt        = state;
      timer_nxt        = timer;
      retry_nxt        = retry;
      parent_id_nxt    = out_parent_id;
      parent_valid_nxt = out_parent_valid;
      if (parent_lost) begin
         parent_valid_nxt = 1'b0;
         retry_nxt        = '0;
         timer_nxt        = '0;
         state_nxt        = JOIN_REQ;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_join_start) begin
                  retry_nxt = '0;
                  state_nxt = JOIN_REQ;
               end
            end
            JOIN_REQ: begin
               if (in_join_req_ready) begin
                  timer_nxt = '0;
                  state_nxt = WAIT_ACK;
               end
            end
            WAIT_ACK: begin
               if (in_join_ack_valid) begin
                  parent_id_nxt    = in_join_ack_id;
                  parent_valid_nxt = 1'b1;
                  state_nxt        = IDLE;
               end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
                  retry_nxt = retry + 1'b1;
                  state_nxt = (int'(retry) + 1 < MAX_RETRY) ? JOIN_REQ : ORPHAN;
               end else begin
                  timer_nxt = timer + 1'b1;
               end
            end
            ORPHAN: begin
               if (in_join_start) begin
                  retry_nxt = '0;
                  state_nxt = JOIN_REQ;
               end else if (in_join_ack_valid) begin
                  parent_id_nxt    = in_join_ack_id;
                  parent_valid_nxt = 1'b1;
                  state_nxt        = IDLE;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

endmodule
